// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 convolution front end and its consumer.
//   PIXEL_W / WINDOW_W   : pixel and packed-window widths
//   pixel_t / window_t   : convenience types
//   win_col_t            : one window column, rows r-2 (top) .. r (bot)
//   WIN_Pij_LSB          : row-major bit offset of tap (i,j), i/j = 0 oldest
//   pack_window()        : builds the 72-bit row-major window from 3 columns
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int PIXEL_W  = 8;
    localparam int WINDOW_W = 9 * PIXEL_W;

    typedef logic [PIXEL_W-1:0]  pixel_t;
    typedef logic [WINDOW_W-1:0] window_t;

    typedef struct packed {
        pixel_t top;  // row r-2
        pixel_t mid;  // row r-1
        pixel_t bot;  // row r
    } win_col_t;

    // Row-major: tap (0,0) = (r-2,c-2) in the top byte, (2,2) = (r,c) at bit 0.
    localparam int WIN_P00_LSB = 64;
    localparam int WIN_P01_LSB = 56;
    localparam int WIN_P02_LSB = 48;
    localparam int WIN_P10_LSB = 40;
    localparam int WIN_P11_LSB = 32;
    localparam int WIN_P12_LSB = 24;
    localparam int WIN_P20_LSB = 16;
    localparam int WIN_P21_LSB = 8;
    localparam int WIN_P22_LSB = 0;

    // c0 is column c-2, c1 is column c-1, c2 is column c.
    function automatic window_t pack_window(input win_col_t c0,
                                            input win_col_t c1,
                                            input win_col_t c2);
        window_t w;
        w = '0;
        w[WIN_P00_LSB +: PIXEL_W] = c0.top;
        w[WIN_P01_LSB +: PIXEL_W] = c1.top;
        w[WIN_P02_LSB +: PIXEL_W] = c2.top;
        w[WIN_P10_LSB +: PIXEL_W] = c0.mid;
        w[WIN_P11_LSB +: PIXEL_W] = c1.mid;
        w[WIN_P12_LSB +: PIXEL_W] = c2.mid;
        w[WIN_P20_LSB +: PIXEL_W] = c0.bot;
        w[WIN_P21_LSB +: PIXEL_W] = c1.bot;
        w[WIN_P22_LSB +: PIXEL_W] = c2.bot;
        return w;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
// One image row of pixel storage. Read is combinational from addr_i; write
// is synchronous to the same address, so a read and write in one cycle
// returns the old contents (read-before-write).
//   clk_i      : clock
//   wr_en_i    : write wr_data_i to mem[addr_i] on the rising edge
//   addr_i     : shared read/write column address
//   wr_data_i  : pixel to store
//   rd_data_o  : current contents of mem[addr_i]
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] addr_i,
    input  pixel_t        wr_data_i,
    output pixel_t        rd_data_o
);

    pixel_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/conv_window_generator.sv
// -----------------------------------------------------------------------------
// conv_window_generator
// Turns a raster pixel stream into 3x3 interior windows for the convolution
// core. Two line buffers supply rows r-1 and r-2; two held columns plus the
// incoming column form the window.
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   in_pixel_data   : raster-order pixel
//   in_pixel_valid  : pixel accepted this cycle
//   in_frame_start  : with in_pixel_valid, this pixel is (0,0)
//   out_pixel_data  : 72-bit row-major window, (r,c) in bits [7:0]
//   out_pixel_valid : one-cycle strobe per window
//
// Stream semantics: there is no ready. A pixel transfers on every cycle where
// in_pixel_valid is high. out_pixel_valid is a pure strobe; out_pixel_data is
// held between strobes.
// -----------------------------------------------------------------------------
module conv_window_generator
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIXEL_W-1:0]  in_pixel_data,
    input  logic                in_pixel_valid,
    input  logic                in_frame_start,
    output logic [WINDOW_W-1:0] out_pixel_data,
    output logic                out_pixel_valid
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(2);
    localparam logic [RW-1:0] ROW_MIN  = RW'(2);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    // Columns c-2 and c-1 of the current window; column c is the live input.
    win_col_t col_m2_q, col_m2_d;
    win_col_t col_m1_q, col_m1_d;
    win_col_t new_col;

    window_t  out_data_q, out_data_d;
    logic     out_valid_q, out_valid_d;

    pixel_t   lb1_rd, lb2_rd;
    logic     emit;

    // A frame start overrides the counters for this very pixel.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (in_frame_start) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    // lb1 holds row r-1, lb2 holds row r-2. Writing lb2 with lb1's old value
    // in the same cycle ages both rows by one in place.
    conv_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) lb1 (
        .clk_i     (clk),
        .wr_en_i   (in_pixel_valid),
        .addr_i    (cur_col),
        .wr_data_i (in_pixel_data),
        .rd_data_o (lb1_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) lb2 (
        .clk_i     (clk),
        .wr_en_i   (in_pixel_valid),
        .addr_i    (cur_col),
        .wr_data_i (lb1_rd),
        .rd_data_o (lb2_rd)
    );

    assign new_col = '{top: lb2_rd, mid: lb1_rd, bot: in_pixel_data};

    // r>=2 and c>=2 keeps all three columns inside the same three rows.
    assign emit = in_pixel_valid && (cur_row >= ROW_MIN) && (cur_col >= COL_MIN);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        col_m2_d    = col_m2_q;
        col_m1_d    = col_m1_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;

        if (in_pixel_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            col_m2_d = col_m1_q;
            col_m1_d = new_col;
        end

        if (emit) begin
            out_data_d  = pack_window(col_m2_q, col_m1_q, new_col);
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            col_m2_q    <= '0;
            col_m1_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            col_m2_q    <= col_m2_d;
            col_m1_q    <= col_m1_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_pixel_data  = out_data_q;
    assign out_pixel_valid = out_valid_q;

endmodule

// File: doc/conv_window_generator.md
# conv_window_generator

Stream-to-window front end for `convolutionOperation`. Accepts one 8-bit pixel per valid cycle in raster order and emits the 72-bit 3x3 neighbourhood that `convolutionOperation` consumes on `in_pixel_data`/`in_pixel_valid`. Uses two row line buffers and a 3-column window shift register. Produces only fully interior windows, (IMG_HEIGHT-2)*(IMG_WIDTH-2) per frame.

## Interface
- `IMG_WIDTH`, default 512: pixels per row, minimum 3.
- `IMG_HEIGHT`, default 512: rows per frame, minimum 3.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_pixel_data` input 8: raster-order pixel.
- `in_pixel_valid` input 1: `in_pixel_data` valid this cycle. The block has no backpressure and accepts every valid pixel.
- `in_frame_start` input 1: sampled only with `in_pixel_valid`. Marks the pixel as (row 0, col 0).
- `out_pixel_data` output 72: 3x3 window, row-major. Bits [71:64] hold (r-2,c-2); bits [7:0] hold (r,c), the newest pixel.
- `out_pixel_valid` output 1: one-cycle strobe per window. Connects directly to `convolutionOperation` `in_pixel_valid`.

## Operation
- Counters:
  - `col`, range 0..IMG_WIDTH-1.
  - `row`, range 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels. `col` wraps to 0 and increments `row`. `row` wraps to 0 after the last pixel of a frame.
- For each accepted pixel p at (r,c):
  - Read `lb1[c]` (row r-1) and `lb2[c]` (row r-2).
  - Shift the column {`lb2[c]`, `lb1[c]`, p} into the window register. The oldest column drops out.
  - Write `lb2[c]` <= old `lb1[c]` and `lb1[c]` <= p in the same cycle. This is read-before-write at the same address.
- Window emitted when r>=2 and c>=2. The condition guarantees all three columns belong to the same three rows, so the window never wraps across a row boundary.
- `in_frame_start` with a valid pixel:
  - The counters are forced so that pixel is (0,0). Counting continues from there.
  - Line buffer contents are not cleared. Row gating makes stale data unreachable.
- `in_frame_start` without `in_pixel_valid` is ignored.
- Row r<2 or col c<2: no output. No border padding.
- Line buffers need no reset. The counters, window register, `out_pixel_data` and `out_pixel_valid` are reset.

## Timing
- Reset values: `out_pixel_valid`=0, `out_pixel_data`=72'h0, counters 0, window register 0.
- Latency: the window containing pixel (r,c) appears with `out_pixel_valid`=1 exactly one cycle after that pixel's valid cycle. The output is registered.
- `out_pixel_valid` is high for one cycle per emitting pixel. Back-to-back valid pixels give back-to-back windows.
- `out_pixel_data` holds its last value while `out_pixel_valid`=0.
- Gaps in `in_pixel_valid` are allowed at any point. State freezes and `out_pixel_valid` goes low.
- Reset asserted mid-frame: outputs clear asynchronously. The next accepted pixel after release is (0,0), whether or not `in_frame_start` is asserted.
- `in_frame_start` arriving mid-row:
  - Any window the previous pixel produced still appears on the following cycle.
  - The new pixel is treated as (0,0) and emits nothing.

## Structure
- Shared package `conv_pkg` holds:
  - `PIXEL_W`=8 and `WINDOW_W`=72.
  - The row-major window bit-slice constants. These are shared with `convolutionOperation`.
- Sub-module `conv_line_buffer`:
  - One IMG_WIDTH x 8 row memory.
  - Combinational read port and synchronous write port on the same address.
  - Instantiated twice as `lb1` and `lb2`.
- The top level holds the counters, the window shift register and the output register.

## Test plan
Scenarios 1–4 use IMG_WIDTH=4 and IMG_HEIGHT=4, with pixel value 4r+c.

1. Full frame, continuous valid, frame_start on the first pixel:
   - Exactly 4 windows.
   - 72'h00_01_02_04_05_06_08_09_0A, one cycle after pixel 10.
   - 72'h01_02_03_05_06_07_09_0A_0B.
   - 72'h04_05_06_08_09_0A_0C_0D_0E.
   - 72'h05_06_07_09_0A_0B_0D_0E_0F.
2. Same frame with `in_pixel_valid` low every other cycle:
   - Identical 4 windows.
   - Each window one cycle after its pixel.
   - `out_pixel_valid` low during gaps with data held.
3. Two frames back-to-back with no gap: the second frame yields the same 4 windows.
4. `in_frame_start` asserted at pixel (1,2) of a frame:
   - No window for the next 9 pixels.
   - The first window appears after the pixel counted as (2,2) and contains the correctly re-aligned values.
5. Reset pulse (`rst_n`=0) mid-row 2, then frame restarted:
   - `out_pixel_valid`=0 and `out_pixel_data`=0 immediately.
   - The subsequent frame produces the scenario-1 windows.
6. Default parameters with a 512x512 frame of random data:
   - 510*510 windows, each matching a reference model.
   - Windows fed into `convolutionOperation` without error.
